// File: rtl/priority_encoder_dual_pipe_if.sv
// rtl/priority_encoder_dual_pipe_if.sv - request/result handshake bundle for the dual priority encoder
//
// Ports (signals):
//   in_valid, in_ready, r               request side (r is the N-bit request vector)
//   out_valid, out_ready, first, second result side (W-bit encoded indices, 0 = none)
//   ptr                                 current highest-priority bit index (visibility)
// Modports: master drives requests and consumes results, slave is the encoder.
interface priority_encoder_dual_pipe_if #(
  parameter int N = 12,
  parameter int W = $clog2(N + 1)
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] first;
  logic [W-1:0] second;
  logic [W-1:0] ptr;

  modport master (
    output in_valid, r, out_ready,
    input  in_ready, out_valid, first, second, ptr
  );

  modport slave (
    input  in_valid, r, out_ready,
    output in_ready, out_valid, first, second, ptr
  );
endinterface

// File: rtl/priority_encoder_dual_pipe.sv
// rtl/priority_encoder_dual_pipe.sv - registered top-two priority encoder, fixed or round-robin order
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      priority_encoder_dual_pipe_if.slave:
//              in_valid/in_ready/r           request accepted when in_valid && in_ready
//              out_valid/out_ready           one-deep registered result, 1-cycle latency
//              first/second                  winner / runner-up index + 1 (0 = none)
//              ptr                           bit index searched first (N-1 in fixed mode)
module priority_encoder_dual_pipe #(
  parameter int N       = 12,
  parameter int RR_MODE = 0
) (
  input logic                        clk,
  input logic                        reset_n,
  priority_encoder_dual_pipe_if.slave bus
);
  localparam int W  = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] TOP = W'(N - 1);

  logic         out_valid_q;
  logic [W-1:0] first_q;
  logic [W-1:0] second_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] first_c;
  logic [W-1:0] second_c;
  logic         accept;

  // Walk downward from ptr with wrap; the first two set bits found win.
  // A zero code doubles as "not yet found" since found codes are 1..N.
  always_comb begin
    int idx;
    idx      = 0;
    first_c  = '0;
    second_c = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) >= i) ? int'(ptr_q) - i : int'(ptr_q) + N - i;
      if (bus.r[IW'(idx)]) begin
        if (first_c == '0) begin
          first_c = W'(idx + 1);
        end else if (second_c == '0) begin
          second_c = W'(idx + 1);
        end
      end
    end
  end

  // Single output register: a new request can enter whenever the slot is
  // empty or being drained this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      first_q     <= '0;
      second_q    <= '0;
      ptr_q       <= TOP;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        first_q     <= first_c;
        second_q    <= second_c;
        // Winner drops to lowest priority: the next search starts just below it.
        if (RR_MODE != 0 && first_c != '0) begin
          ptr_q <= (first_c == W'(1)) ? TOP : first_c - W'(2);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.first     = first_q;
  assign bus.second    = second_q;
  assign bus.ptr       = ptr_q;
endmodule

// File: tb/tb_priority_encoder_dual_pipe.sv
// tb/tb_priority_encoder_dual_pipe.sv - scoreboard bench for fixed and round-robin encoder instances
module tb_priority_encoder_dual_pipe;
  localparam int N = 12;

  typedef struct packed {
    logic [3:0] f;
    logic [3:0] s;
    logic [3:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t qf[$];
  exp_t qr[$];

  always #5 clk = ~clk;

  priority_encoder_dual_pipe_if #(.N(N)) bf ();
  priority_encoder_dual_pipe_if #(.N(N)) br ();

  priority_encoder_dual_pipe #(.N(N), .RR_MODE(0)) u_fix (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bf)
  );

  priority_encoder_dual_pipe #(.N(N), .RR_MODE(1)) u_rr (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (br)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a result is consumed.
  task automatic pop_cmp(input bit sel, input int f, input int s, input int p);
    exp_t  e;
    string nm;
    nm = sel ? "rr" : "fix";
    if ((sel && qr.size() == 0) || (!sel && qf.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_result actual=first%0d/second%0d expected=none at %0t", nm, f, s, $time);
    end else begin
      e = sel ? qr.pop_front() : qf.pop_front();
      chk({nm, "_first"}, f, int'(e.f));
      chk({nm, "_second"}, s, int'(e.s));
      chk({nm, "_ptr"}, p, int'(e.p));
    end
  endtask

  always @(negedge clk) begin
    if (bf.out_valid && bf.out_ready) pop_cmp(1'b0, int'(bf.first), int'(bf.second), int'(bf.ptr));
    if (br.out_valid && br.out_ready) pop_cmp(1'b1, int'(br.first), int'(br.second), int'(br.ptr));
  end

  // Called at posedge+1; offers rv for one cycle and expects it to be taken.
  task automatic issue(input bit sel, input logic [11:0] rv, input int ef, input int es, input int ep);
    exp_t e;
    e.f = 4'(ef);
    e.s = 4'(es);
    e.p = 4'(ep);
    if (sel) begin br.in_valid = 1'b1; br.r = rv; end
    else     begin bf.in_valid = 1'b1; bf.r = rv; end
    @(negedge clk);
    chk(sel ? "rr_in_ready" : "fix_in_ready", sel ? int'(br.in_ready) : int'(bf.in_ready), 1);
    if (sel) qr.push_back(e); else qf.push_back(e);
    @(posedge clk); #1;
    if (sel) br.in_valid = 1'b0; else bf.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bf.in_valid = 1'b1; bf.r = 12'hFFF; bf.out_ready = 1'b1;
    br.in_valid = 1'b1; br.r = 12'hFFF; br.out_ready = 1'b1;

    // Reset held with in_valid high: nothing captured.
    repeat (2) @(negedge clk);
    chk("fix_rst_out_valid", int'(bf.out_valid), 0);
    chk("fix_rst_first", int'(bf.first), 0);
    chk("fix_rst_second", int'(bf.second), 0);
    chk("fix_rst_ptr", int'(bf.ptr), 11);
    chk("fix_rst_in_ready", int'(bf.in_ready), 1);
    chk("rr_rst_out_valid", int'(br.out_valid), 0);
    chk("rr_rst_first", int'(br.first), 0);
    chk("rr_rst_second", int'(br.second), 0);
    chk("rr_rst_ptr", int'(br.ptr), 11);
    chk("rr_rst_in_ready", int'(br.in_ready), 1);
    @(posedge clk); #1;
    bf.in_valid = 1'b0;
    br.in_valid = 1'b0;
    reset_n = 1'b1;

    // Fixed mode streaming
    issue(1'b0, 12'h800, 12, 0, 11);
    issue(1'b0, 12'h0A4, 8, 6, 11);
    issue(1'b0, 12'h001, 1, 0, 11);
    issue(1'b0, 12'h000, 0, 0, 11);
    idle(2);

    // Backpressure: result first=5 held, offered 12'h400 not captured
    bf.out_ready = 1'b0;
    issue(1'b0, 12'h013, 5, 2, 11);
    bf.in_valid = 1'b1;
    bf.r = 12'h400;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fix_stall_in_ready", int'(bf.in_ready), 0);
      chk("fix_stall_out_valid", int'(bf.out_valid), 1);
      chk("fix_stall_first", int'(bf.first), 5);
      @(posedge clk); #1;
    end
    qf.push_back('{f: 4'd11, s: 4'd0, p: 4'd11});
    bf.out_ready = 1'b1;
    @(posedge clk); #1;
    bf.in_valid = 1'b0;
    idle(2);

    // Round-robin rotation and wrap
    issue(1'b1, 12'hFFF, 12, 11, 10);
    issue(1'b1, 12'hFFF, 11, 10, 9);
    issue(1'b1, 12'hFFF, 10, 9, 8);
    issue(1'b1, 12'h002, 2, 0, 0);
    issue(1'b1, 12'h001, 1, 0, 11);
    issue(1'b1, 12'h801, 12, 1, 10);
    issue(1'b1, 12'h801, 1, 12, 11);
    idle(2);

    // Asynchronous reset during a stall
    br.out_ready = 1'b0;
    issue(1'b1, 12'h0F0, 8, 7, 6);
    #1;
    chk("rr_prerst_out_valid", int'(br.out_valid), 1);
    chk("rr_prerst_ptr", int'(br.ptr), 6);
    reset_n = 1'b0;
    #1;
    chk("rr_async_out_valid", int'(br.out_valid), 0);
    chk("rr_async_ptr", int'(br.ptr), 11);
    chk("rr_async_first", int'(br.first), 0);
    chk("rr_async_second", int'(br.second), 0);
    chk("rr_async_in_ready", int'(br.in_ready), 1);
    qr.delete();
    br.out_ready = 1'b1;
    idle(2);
    reset_n = 1'b1;
    idle(3);
    chk("rr_post_rst_out_valid", int'(br.out_valid), 0);
    chk("fix_post_rst_out_valid", int'(bf.out_valid), 0);
    chk("fix_queue_drained", qf.size(), 0);
    chk("rr_queue_drained", qr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
